// File: rtl/binary_bcd_seq_display.sv
// Sequential binary-to-BCD converter with 7-segment display output.
// A start pulse in IDLE captures `binary`. The double-dabble (shift-add-3)
// algorithm then converts it over WIDTH cycles, and the block presents
// registered BCD digits and active-low segment patterns.
// Ports:
//   clock, resetn    : clock, asynchronous active-low reset
//   start            : conversion request, sampled only in IDLE
//   binary[WIDTH]    : value to convert, sampled on the accepting edge
//   busy             : conversion in progress
//   done             : one-cycle pulse when bcd/hex/overflow update
//   overflow         : last result did not fit in DIGITS digits
//   bcd[4*DIGITS]    : result, digit 0 (units) at [3:0]
//   hex[7*DIGITS]    : segment patterns, digit 0 at [6:0], bit 6 = a .. bit 0 = g
module binary_bcd_seq_display #(
   parameter int unsigned WIDTH         = 7,
   parameter int unsigned DIGITS        = 3,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]    scratch, scratch_n, corr;
   logic [CW-1:0]    cnt, cnt_n;
   logic             flag, flag_n;
   logic             busy_n, done_n, overflow_n;
   logic [BW-1:0]    bcd_n;
   logic             seen;
   logic [3:0]       dig;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111110;
      endcase
   endfunction

   // Add-3 correction: each digit >= 5 gets +3, no carry between digits.
   always_comb begin
      corr = scratch;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            corr[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      scratch_n  = scratch;
      cnt_n      = cnt;
      flag_n     = flag;
      busy_n     = busy;
      done_n     = 1'b0;
      overflow_n = overflow;
      bcd_n      = bcd;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_n   = binary;
               scratch_n = '0;
               flag_n    = 1'b0;
               cnt_n     = CW'(WIDTH);
               busy_n    = 1'b1;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            // A set corrected MSB would be lost by the shift: result cannot fit.
            if (corr[BW-1])
               flag_n = 1'b1;
            {scratch_n, shreg_n} = {corr, shreg} << 1;
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1))
               state_n = DONE;
         end
         DONE: begin
            overflow_n = flag;
            bcd_n      = flag ? '1 : scratch;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         flag     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         bcd      <= '0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         scratch  <= scratch_n;
         cnt      <= cnt_n;
         flag     <= flag_n;
         busy     <= busy_n;
         done     <= done_n;
         overflow <= overflow_n;
         bcd      <= bcd_n;
      end
   end

   // Segment decode from the registered result, scanning from the top digit
   // so leading zeros can be blanked; digit 0 always shows.
   always_comb begin
      hex  = '1;
      seen = 1'b0;
      dig  = 4'd0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         dig = bcd[4*i +: 4];
         if (dig != 4'd0)
            seen = 1'b1;
         if (overflow)
            hex[7*i +: 7] = 7'b1111110;
         else if (BLANK_LEADING && !seen && (i > 0))
            hex[7*i +: 7] = 7'b1111111;
         else
            hex[7*i +: 7] = seg7(dig);
      end
   end

endmodule

// File: tb/tb_binary_bcd_seq_display.sv
module tb_binary_bcd_seq_display;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [9:0]  binary;
   logic [2:0]  busy, done, ovf;
   logic [11:0] bcd_o [3];
   logic [20:0] hex_o [3];

   int          n_vec = 0;
   int          n_err = 0;
   int          wd [3] = '{7, 10, 7};
   bit          bl [3] = '{1'b1, 1'b1, 1'b0};
   logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};
   logic [15:0] busy_tr [3];
   logic [15:0] done_tr [3];

   always #5 clk = ~clk;

   // Instance 0: WIDTH=7 blanking; 1: WIDTH=10 blanking; 2: WIDTH=7 no blanking.
   binary_bcd_seq_display #(.WIDTH(7), .DIGITS(3), .BLANK_LEADING(1'b1)) u_w7 (
      .clock(clk), .resetn(resetn), .start(start), .binary(binary[6:0]),
      .busy(busy[0]), .done(done[0]), .overflow(ovf[0]), .bcd(bcd_o[0]), .hex(hex_o[0]));
   binary_bcd_seq_display #(.WIDTH(10), .DIGITS(3), .BLANK_LEADING(1'b1)) u_w10 (
      .clock(clk), .resetn(resetn), .start(start), .binary(binary),
      .busy(busy[1]), .done(done[1]), .overflow(ovf[1]), .bcd(bcd_o[1]), .hex(hex_o[1]));
   binary_bcd_seq_display #(.WIDTH(7), .DIGITS(3), .BLANK_LEADING(1'b0)) u_w7n (
      .clock(clk), .resetn(resetn), .start(start), .binary(binary[6:0]),
      .busy(busy[2]), .done(done[2]), .overflow(ovf[2]), .bcd(bcd_o[2]), .hex(hex_o[2]));

   // Reference: decimal digits by division; values >= 1000 overflow 3 digits.
   function automatic logic [11:0] m_bcd(input int v);
      if (v >= 1000) return 12'hFFF;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [20:0] m_hex(input int v, input bit b);
      logic [20:0] h;
      int p;
      p = 1;
      for (int k = 0; k < 3; k++) begin
         if (v >= 1000)               h[7*k +: 7] = 7'b1111110;
         else if (b && k > 0 && v < p) h[7*k +: 7] = 7'b1111111;
         else                          h[7*k +: 7] = seg_tab[(v / p) % 10];
         p = p * 10;
      end
      return h;
   endfunction

   // Drives one conversion and records busy/done for 16 cycles after the accepting edge.
   // noisy: re-pulse start and change binary to 3 during SHIFT.
   task automatic run_conv(input int v, input bit noisy);
      @(negedge clk);
      binary = 10'(v);
      start  = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (noisy && k == 2) begin start = 1'b1; binary = 10'd3; end
         if (noisy && k == 3) start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            busy_tr[i][k] = busy[i];
            done_tr[i][k] = done[i];
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; binary = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({busy[i], done[i], ovf[i]} !== 3'b000 || bcd_o[i] !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outs[%0d] got busy/done/ovf=%b bcd=%h want 000 000", i, {busy[i], done[i], ovf[i]}, bcd_o[i]);
         end
         n_vec++;
         if (hex_o[i] !== m_hex(0, bl[i])) begin
            n_err++;
            $display("FAIL reset_hex[%0d] got %b want %b", i, hex_o[i], m_hex(0, bl[i]));
         end
      end
      resetn = 1'b1;
   endtask

   // Values with spec-given results plus timing of busy/done.
   task automatic test_basic();
      int vals [3] = '{127, 5, 0};
      foreach (vals[j]) begin
         run_conv(vals[j], 1'b0);
         for (int i = 0; i < 3; i++) begin
            int vi = vals[j] % (1 << wd[i]);
            n_vec++;
            if (done_tr[i] !== 16'(1 << (wd[i] + 1))) begin
               n_err++; $display("FAIL basic_done[%0d] v=%0d got %b want %b", i, vi, done_tr[i], 16'(1 << (wd[i] + 1)));
            end
            n_vec++;
            if (busy_tr[i] !== 16'((1 << (wd[i] + 1)) - 1)) begin
               n_err++; $display("FAIL basic_busy[%0d] v=%0d got %b want %b", i, vi, busy_tr[i], 16'((1 << (wd[i] + 1)) - 1));
            end
            n_vec++;
            if (bcd_o[i] !== m_bcd(vi) || ovf[i] !== 1'b0) begin
               n_err++; $display("FAIL basic_bcd[%0d] v=%0d got %h/%b want %h/0", i, vi, bcd_o[i], ovf[i], m_bcd(vi));
            end
            n_vec++;
            if (hex_o[i] !== m_hex(vi, bl[i])) begin
               n_err++; $display("FAIL basic_hex[%0d] v=%0d got %b want %b", i, vi, hex_o[i], m_hex(vi, bl[i]));
            end
         end
      end
   endtask

   // Overflow at 1000 on the 10-bit instance, cleared by a later conversion.
   task automatic test_overflow();
      int vals [3] = '{999, 1000, 42};
      foreach (vals[j]) begin
         run_conv(vals[j], 1'b0);
         for (int i = 0; i < 3; i++) begin
            int vi = vals[j] % (1 << wd[i]);
            n_vec++;
            if (bcd_o[i] !== m_bcd(vi) || ovf[i] !== 1'(vi >= 1000)) begin
               n_err++; $display("FAIL ovf_bcd[%0d] v=%0d got %h/%b want %h/%b", i, vi, bcd_o[i], ovf[i], m_bcd(vi), vi >= 1000);
            end
            n_vec++;
            if (hex_o[i] !== m_hex(vi, bl[i])) begin
               n_err++; $display("FAIL ovf_hex[%0d] v=%0d got %b want %b", i, vi, hex_o[i], m_hex(vi, bl[i]));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 20; j++) begin
         int v = int'($urandom_range(0, 1023));
         run_conv(v, 1'b0);
         for (int i = 0; i < 3; i++) begin
            int vi = v % (1 << wd[i]);
            n_vec++;
            if (bcd_o[i] !== m_bcd(vi) || ovf[i] !== 1'(vi >= 1000) || hex_o[i] !== m_hex(vi, bl[i])) begin
               n_err++; $display("FAIL rand[%0d] v=%0d got %h/%b/%b want %h/%b/%b", i, vi, bcd_o[i], ovf[i], hex_o[i], m_bcd(vi), vi >= 1000, m_hex(vi, bl[i]));
            end
         end
      end
   endtask

   // Start re-pulse and binary change during SHIFT must not affect the result.
   task automatic test_ignore_start();
      run_conv(100, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (done_tr[i] !== 16'(1 << (wd[i] + 1))) begin
            n_err++; $display("FAIL ignore_done[%0d] got %b want %b", i, done_tr[i], 16'(1 << (wd[i] + 1)));
         end
         n_vec++;
         if (bcd_o[i] !== 12'h100) begin
            n_err++; $display("FAIL ignore_bcd[%0d] got %h want 100", i, bcd_o[i]);
         end
      end
   endtask

   // Reset during SHIFT aborts without Done; a later conversion works normally.
   task automatic test_abort();
      logic [2:0] seen_done;
      seen_done = '0;
      @(negedge clk);
      binary = 10'd77; start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk) resetn = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (busy[i] !== 1'b0 || done[i] !== 1'b0 || bcd_o[i] !== 12'h000 || hex_o[i] !== m_hex(0, bl[i])) begin
            n_err++; $display("FAIL abort_state[%0d] got busy=%b done=%b bcd=%h hex=%b want 0 0 000 %b", i, busy[i], done[i], bcd_o[i], hex_o[i], m_hex(0, bl[i]));
         end
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (14) begin
         @(negedge clk);
         seen_done = seen_done | done;
      end
      n_vec++;
      if (seen_done !== 3'b000) begin
         n_err++; $display("FAIL abort_nodone got %b want 000", seen_done);
      end
      run_conv(64, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (bcd_o[i] !== 12'h064) begin
            n_err++; $display("FAIL abort_next[%0d] got %h want 064", i, bcd_o[i]);
         end
      end
   endtask

   // Start held high: Done every WIDTH+2 cycles, result of 0 shown.
   task automatic test_back_to_back();
      logic [39:0] tr [3];
      logic [39:0] ex;
      @(negedge clk);
      binary = 10'd0; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) tr[i][k] = done[i];
      end
      start = 1'b0;
      repeat (14) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         ex = '0;
         for (int p = wd[i] + 1; p < 40; p += wd[i] + 2) ex[p] = 1'b1;
         n_vec++;
         if (tr[i] !== ex) begin
            n_err++; $display("FAIL b2b_done[%0d] got %b want %b", i, tr[i], ex);
         end
         n_vec++;
         if (bcd_o[i] !== 12'h000 || hex_o[i] !== m_hex(0, bl[i])) begin
            n_err++; $display("FAIL b2b_zero[%0d] got %h/%b want 000/%b", i, bcd_o[i], hex_o[i], m_hex(0, bl[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_ignore_start();
      test_abort();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/binary_bcd_seq_display.md
# binary_bcd_seq_display

Parametrised sequential binary-to-BCD converter with 7-segment output, successor of the combinational 7-bit/3-digit converter. A Start pulse captures a WIDTH-bit binary value, and the double-dabble (shift-add-3) algorithm converts it over WIDTH clock cycles. The block then presents registered BCD digits and active-low 7-segment patterns, with optional leading-zero blanking and overflow indication. It sits between switch/counter sources and the HEX display pins.

## Interface
- WIDTH, 7: binary input width; legal range 1..32.
- DIGITS, 3: number of BCD digits and 7-segment displays; legal range 1..10.
- BLANK_LEADING, 1: when 1, zero digits above the most significant non-zero digit are blanked.
- Clock  in  1  single clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  conversion request; sampled only in IDLE.
- Binary  in  WIDTH  value to convert; sampled only on the accepting edge.
- Busy  out  1  high while a conversion is in progress.
- Done  out  1  one-cycle pulse; Bcd, Hex and Overflow are updated on the same edge.
- Overflow  out  1  last result did not fit in DIGITS digits; held until the next Done.
- Bcd  out  4*DIGITS  result, digit 0 (units) at [3:0].
- Hex  out  7*DIGITS  segment patterns, digit 0 at [6:0]; per digit bit 6 = a … bit 0 = g, active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with Start=1:
  - load shift register with Binary;
  - clear scratch (4*DIGITS bits) and the overflow flag;
  - counter := WIDTH; go to SHIFT.
- IDLE with Start=0: remain in IDLE.
- SHIFT, each cycle:
  - for every scratch digit ≥5, add 3 (4-bit, no carry between digits);
  - if the corrected scratch MSB is 1, set the sticky overflow flag;
  - shift {scratch, shift register} left by one;
  - decrement counter; go to DONE when the counter reaches 0.
- DONE, one cycle:
  - on exit edge, register the result and go to IDLE;
  - Overflow := flag; Bcd := scratch, or all 4'hF if the flag is set; Done := 1.
- Start is ignored in SHIFT and DONE, with no queuing. Changes on Binary after the accepting edge have no effect.
- Segment decode of each Bcd digit (a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Overflow display: every digit shows dash 1111110.
- Blanking (BLANK_LEADING=1, no overflow): digit i>0 shows 1111111 if it and all higher digits are 0. Digit 0 is never blanked.
- Hex is decoded combinationally from the registered Bcd and Overflow; no extra latency.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Overflow=0, Bcd=0.
  - Hex: digit 0 = 0000001; higher digits 1111111 if BLANK_LEADING, else 0000001.
- Reset asserted mid-conversion aborts immediately. No Done is produced; outputs take reset values.
- Start sampled high in IDLE at edge t:
  - Busy=1 after edge t;
  - shifts occur on edges t+1..t+WIDTH;
  - DONE state holds during cycle t+WIDTH..t+WIDTH+1;
  - edge t+WIDTH+1 updates Bcd/Hex/Overflow, raises Done for exactly one cycle and drops Busy.
- Next Start is accepted at edge t+WIDTH+2 at the earliest. Throughput is one conversion per WIDTH+2 cycles.
- Bcd, Hex and Overflow hold between Done pulses.

## Test plan
- WIDTH=7, DIGITS=3, Binary=127, Start at edge t:
  - Done only in the cycle after edge t+8;
  - Bcd=12'h127, Overflow=0;
  - Hex digit2=1001111, digit1=0010010, digit0=0001111.
- Binary=5:
  - Bcd=12'h005; digit0=0100100;
  - digits 2 and 1 = 1111111, or 0000001 each with BLANK_LEADING=0.
- WIDTH=10, DIGITS=3:
  - Binary=999 → Bcd=12'h999, Overflow=0;
  - Binary=1000 → Overflow=1, Bcd=12'hFFF, all digits 1111110;
  - a following conversion of 42 clears Overflow.
- Start re-pulsed and Binary changed from 100 to 3 during SHIFT: no restart; result Bcd=12'h100; a single Done pulse.
- Resetn low at edge t+3 of a conversion: Busy=0, no Done, reset Hex pattern; a new Start of 64 then yields Bcd=12'h064.
- Binary=0: Bcd=0, digit0=0000001, others blank; back-to-back Starts held high continuously produce Done every WIDTH+2 cycles.
